// File: rtl/iobridge_pkg.sv
// rtl/iobridge_pkg.sv - shared state codes, defaults and lane helper for the I/O bridge
package iobridge_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK  = 2'd1;
    localparam logic [1:0] ST_WAIT_NACK = 2'd2;
    localparam logic [1:0] ST_POST      = 2'd3;

    localparam logic [11:0] IO_BASE_DEFAULT = 12'hFFD;

    // Index of the lowest set byte select; 0 when no select is set.
    function automatic logic [2:0] lane_encode(input logic [7:0] sel);
        lane_encode = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (sel[i]) lane_encode = 3'(i);
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter; last grant advances only on request
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] last_q, last_d;
    logic          found;
    int            j;

    // Scan from last_grant+1 upward with wrap; first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = last_q;
        found     = 1'b0;
        j         = 0;
        for (int off = 1; off <= N; off++) begin
            j = int'(last_q) + off;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (advance && found) last_d = grant_idx;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) last_q <= IW'(N - 1);
        else       last_q <= last_d;
    end

endmodule

// File: rtl/io_bridge_nport.sv
// rtl/io_bridge_nport.sv - N-port round-robin bridge onto the shared low-speed I/O bus
module io_bridge_nport
    import iobridge_pkg::*;
#(
    parameter int          NPORT   = 2,
    parameter int          DW      = 32,
    parameter logic [11:0] IO_BASE = IO_BASE_DEFAULT,
    parameter int          WR_POST = 0,
    parameter int          TIMEOUT = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NPORT-1:0]        s_cyc_i,
    input  logic [NPORT-1:0]        s_stb_i,
    input  logic [NPORT-1:0]        s_we_i,
    input  logic [NPORT*DW/8-1:0]   s_sel_i,
    input  logic [NPORT*32-1:0]     s_adr_i,
    input  logic [NPORT*DW-1:0]     s_dat_i,
    output logic [NPORT-1:0]        s_ack_o,
    output logic [NPORT-1:0]        s_err_o,
    output logic [NPORT*DW-1:0]     s_dat_o,
    output logic                    m_cyc_o,
    output logic                    m_stb_o,
    output logic                    m_we_o,
    output logic [DW/8-1:0]         m_sel_o,
    output logic [31:0]             m_adr_o,
    output logic [DW-1:0]           m_dat_o,
    output logic [7:0]              m_dat8_o,
    input  logic                    m_ack_i,
    input  logic [DW-1:0]           m_dat_i
);

    localparam int SW = DW / 8;
    localparam int LW = $clog2(SW);
    localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);

    logic [1:0]          state_q, state_d;
    logic [IW-1:0]       gnt_q, gnt_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                m_cyc_q, m_cyc_d, m_we_q, m_we_d;
    logic [SW-1:0]       m_sel_q, m_sel_d;
    logic [31:0]         m_adr_q, m_adr_d;
    logic [DW-1:0]       m_dat_q, m_dat_d;
    logic [7:0]          m_dat8_q, m_dat8_d;
    logic [NPORT-1:0]    s_ack_q, s_ack_d, s_err_q, s_err_d;
    logic [NPORT*DW-1:0] s_dat_q, s_dat_d;

    logic [NPORT-1:0]    req, arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic                advance;
    logic [31:0]         g_adr;
    logic [DW-1:0]       g_dat;
    logic [SW-1:0]       g_sel;
    logic [LW-1:0]       lane;
    logic                unused_adr_lo;
    logic                tmo_expired;

    always_comb begin
        req           = '0;
        unused_adr_lo = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            req[p]        = s_cyc_i[p] && (s_adr_i[p*32+20 +: 12] == IO_BASE);
            unused_adr_lo = unused_adr_lo ^ (^s_adr_i[p*32 +: LW]);
        end
    end

    rr_arbiter #(.N(NPORT), .IW(IW)) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req       (req),
        .advance   (advance),
        .grant     (arb_gnt),
        .grant_idx (arb_idx)
    );

    assign g_adr       = s_adr_i[arb_idx*32 +: 32];
    assign g_dat       = s_dat_i[arb_idx*DW +: DW];
    assign g_sel       = s_sel_i[arb_idx*SW +: SW];
    assign lane        = LW'(lane_encode(8'(g_sel)));
    assign tmo_expired = (TIMEOUT > 0) && (tmo_q == '0);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        tmo_d    = tmo_q;
        m_cyc_d  = m_cyc_q;
        m_we_d   = m_we_q;
        m_sel_d  = m_sel_q;
        m_adr_d  = m_adr_q;
        m_dat_d  = m_dat_q;
        m_dat8_d = m_dat8_q;
        s_ack_d  = s_ack_q;
        s_err_d  = s_err_q;
        s_dat_d  = s_dat_q;
        advance  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A lingering device ack from a truncated cycle blocks new grants.
                if (!m_ack_i && (|req)) begin
                    advance  = 1'b1;
                    gnt_d    = arb_idx;
                    tmo_d    = TMO_LOAD;
                    m_cyc_d  = 1'b1;
                    m_we_d   = s_we_i[arb_idx];
                    m_sel_d  = g_sel;
                    m_adr_d  = {IO_BASE, g_adr[19:LW], lane};
                    m_dat_d  = g_dat;
                    m_dat8_d = g_dat[lane*8 +: 8];
                    if ((WR_POST != 0) && s_we_i[arb_idx]) begin
                        s_ack_d = s_ack_q | arb_gnt;
                        state_d = ST_POST;
                    end else begin
                        state_d = ST_WAIT_ACK;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (m_ack_i) begin
                    if (!m_we_q) s_dat_d[gnt_q*DW +: DW] = m_dat_i;
                    s_ack_d[gnt_q] = 1'b1;
                    m_cyc_d        = 1'b0;
                    m_we_d         = 1'b0;
                    state_d        = ST_WAIT_NACK;
                end else if (!s_cyc_i[gnt_q]) begin
                    m_cyc_d = 1'b0;
                    m_we_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (tmo_expired) begin
                    s_err_d[gnt_q] = 1'b1;
                    m_cyc_d        = 1'b0;
                    m_we_d         = 1'b0;
                    state_d        = ST_WAIT_NACK;
                end else if (TIMEOUT > 0) begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            ST_WAIT_NACK: begin
                if (!s_stb_i[gnt_q]) begin
                    s_ack_d[gnt_q] = 1'b0;
                    s_err_d[gnt_q] = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            ST_POST: begin
                if (!s_stb_i[gnt_q]) s_ack_d[gnt_q] = 1'b0;
                if (m_cyc_q) begin
                    if (m_ack_i || tmo_expired) begin
                        m_cyc_d = 1'b0;
                        m_we_d  = 1'b0;
                    end else if (TIMEOUT > 0) begin
                        tmo_d = tmo_q - TW'(1);
                    end
                end
                if (!m_cyc_q && !s_stb_i[gnt_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            tmo_q    <= '0;
            m_cyc_q  <= 1'b0;
            m_we_q   <= 1'b0;
            m_sel_q  <= '0;
            m_adr_q  <= '0;
            m_dat_q  <= '0;
            m_dat8_q <= '0;
            s_ack_q  <= '0;
            s_err_q  <= '0;
            s_dat_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            tmo_q    <= tmo_d;
            m_cyc_q  <= m_cyc_d;
            m_we_q   <= m_we_d;
            m_sel_q  <= m_sel_d;
            m_adr_q  <= m_adr_d;
            m_dat_q  <= m_dat_d;
            m_dat8_q <= m_dat8_d;
            s_ack_q  <= s_ack_d;
            s_err_q  <= s_err_d;
            s_dat_q  <= s_dat_d;
        end
    end

    assign s_ack_o  = s_ack_q;
    assign s_err_o  = s_err_q;
    assign s_dat_o  = s_dat_q;
    assign m_cyc_o  = m_cyc_q;
    assign m_stb_o  = m_cyc_q;
    assign m_we_o   = m_we_q;
    assign m_sel_o  = m_sel_q;
    assign m_adr_o  = m_adr_q;
    assign m_dat_o  = m_dat_q;
    assign m_dat8_o = m_dat8_q;

endmodule

// File: doc/io_bridge_nport.md
# io_bridge_nport

Parametrised I/O bridge sitting between NPORT bus masters (CPU data port, DMA, debug) and the shared low-speed I/O device bus. It filters requests to the I/O window and arbitrates round-robin among requesting ports. It registers the whole master-side transaction, optionally posts writes, and aborts hung device cycles with a timeout error. To every requester it looks like a single device.

## Interface
- NPORT, 2: number of slave (requester) ports, 1..8
- DW, 32: data width, 32 or 64; SW = DW/8 byte selects
- IO_BASE, 12'hFFD: required value of adr[31:20] for a request to be accepted
- WR_POST, 0: 1 = writes acknowledged to the requester before the device acks
- TIMEOUT, 255: cycles to wait for m_ack_i; 0 disables the timeout
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  reset, asynchronous, active-high
- s_cyc_i, s_stb_i, s_we_i  in  NPORT  per-port cycle, strobe, write
- s_sel_i  in  NPORT×SW  per-port byte selects
- s_adr_i  in  NPORT×32  per-port byte address
- s_dat_i  in  NPORT×DW  per-port write data
- s_ack_o, s_err_o  out  NPORT  per-port acknowledge, error (registered)
- s_dat_o  out  NPORT×DW  per-port read data (registered)
- m_cyc_o, m_stb_o, m_we_o  out  1  device-bus cycle, strobe, write
- m_sel_o  out  SW  byte selects
- m_adr_o  out  32  {IO_BASE, adr[19:log2 SW], lane}; lane = index of the lowest set sel bit
- m_dat_o  out  DW  write data
- m_dat8_o  out  8  write byte taken from lane
- m_ack_i  in  1  device acknowledge
- m_dat_i  in  DW  device read data

## Operation
- Eligible port: s_cyc_i && s_adr_i[31:20]==IO_BASE. Out-of-window requests are never acknowledged and never granted.
- Arbitration happens in IDLE only, and only while m_ack_i is low. The grant goes to the first eligible port scanning from last_grant+1 upward with wrap. last_grant resets to NPORT-1, so port 0 wins first.
- On grant, register all m_* outputs, set m_cyc_o=m_stb_o=1, and load the timeout counter.
- States:
  - IDLE.
  - WAIT_ACK: read, or write with WR_POST=0.
  - WAIT_NACK: hold s_ack_o/s_err_o until the requester drops its strobe.
  - POST: posted write in flight.
- WAIT_ACK:
  - On m_ack_i: capture m_dat_i into s_dat_o[g], set s_ack_o[g], drop m_cyc/stb/we, go to WAIT_NACK.
  - If the granted s_cyc_i drops first (abort): drop the master, go to IDLE, no ack.
  - If the counter hits 0: drop the master, set s_err_o[g], go to WAIT_NACK.
- WAIT_NACK: when s_stb_i[g]=0, clear ack/err and go to IDLE.
- POST (WR_POST=1, write granted):
  - s_ack_o[g] is set on the grant edge and cleared once s_stb_i[g]=0.
  - The master cycle stays up until m_ack_i or timeout. A timeout here is silent.
  - Leave for IDLE only when the master cycle has ended and the strobe is low.
- Other ports' strobes never affect the granted transaction.
- s_dat_o[p] holds its last value until the next read completes for port p.

## Timing
- Reset values: all s_ack_o, s_err_o, m_cyc_o, m_stb_o and m_we_o are 0. m_sel_o=0, m_adr_o=0, m_dat_o=0, m_dat8_o=0, s_dat_o=0. State is IDLE.
- Request seen at edge 0 → m_cyc_o high after edge 1.
- m_ack_i sampled at edge k → s_ack_o and s_dat_o valid after edge k+1. Best read round trip with a 1-cycle device is 3 cycles.
- Posted write: s_ack_o high after edge 1, the same edge as m_cyc_o.
- Timeout: with TIMEOUT=N and no ack, s_err_o rises N+1 cycles after m_cyc_o rises.
- Returning to IDLE costs one cycle, so back-to-back grants are spaced at least 1 idle cycle apart.
- If m_ack_i and timeout expiry coincide, ack wins. If an abort and m_ack_i coincide, ack wins (data delivered).
- An asynchronous reset mid-cycle drops m_cyc_o immediately. The device must tolerate a truncated cycle.

## Structure
- iobridge_pkg: the state enum (IDLE, WAIT_ACK, WAIT_NACK, POST), IO_BASE default, and a lane-encode function (lowest set sel bit).
- Sub-module rr_arbiter #(N): inputs req[N] and advance; outputs one-hot grant and grant index. The last_grant register lives inside it and updates only on advance.
- The timeout counter is $clog2(TIMEOUT+1) bits wide, kept in the top level.

## Test plan
- Port 0 read 0xFFD00010 with a device acking 1 cycle after stb and returning 0x12345678 → m_adr_o=0xFFD00010; s_ack_o[0] high 3 cycles after the request, s_dat_o[0]=0x12345678.
- Port 1 byte write sel=4'b0100, dat=0xAABBCCDD, adr 0xFFD00020 → m_adr_o=0xFFD00022, m_dat8_o=0xBB, m_we_o=1.
- Ports 0 and 1 request continuously, NPORT=2 → grants alternate 0,1,0,1; request to 0x00001000 → no m_cyc_o, no ack.
- Device never acks, TIMEOUT=4 → s_err_o[g] rises 5 cycles after m_cyc_o and clears when the strobe drops.
- WR_POST=1 write with the device acking after 6 cycles → s_ack_o on cycle 1; next grant only after m_ack_i and strobe low.
- Port 0 drops s_cyc_i in WAIT_ACK → m_cyc_o low next cycle, no s_ack_o; rst_i mid-cycle → all outputs 0 asynchronously.
